uart_frame_decoder: RTL and testbench

Byte-stream frame decoder sitting directly downstream of the UART receiver. It consumes received bytes over the receiver's valid/ack handshake and hunts for a sync byte. It collects a length-prefixed payload, verifies an XOR checksum, and releases only verified payloads on a valid/ready byte stream with a last marker. Bad, oversized or stalled frames are discarded, and each discard is reported with an error pulse and code.

---
 rtl/uart_frame_pkg.sv | 12 +
 rtl/uart_frame_decoder_if.sv | 24 ++
 rtl/uart_frame_decoder_frame_buf.sv | 21 ++
 rtl/uart_frame_decoder.sv | 184 ++++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame decoder slice.
package uart_frame_pkg;

   typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, SEND} state_t;

   localparam logic [1:0] ERR_LEN = 2'd1;
   localparam logic [1:0] ERR_CHK = 2'd2;
   localparam logic [1:0] ERR_TMO = 2'd3;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Receiver-side valid/ack byte input, verified-payload stream output and status.
interface uart_frame_decoder_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ack;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic [7:0] drop_cnt;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ack, out_data, out_valid, out_last, frame_ok, frame_err, err_code, drop_cnt
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ack, out_data, out_valid, out_last, frame_ok, frame_err, err_code, drop_cnt
   );
endinterface

// File: rtl/uart_frame_decoder_frame_buf.sv
// Simple dual-port payload RAM: synchronous write, registered read (EBR friendly).
module frame_buf #(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/uart_frame_decoder.sv
// Sync-hunting, length-prefixed, XOR-checked frame decoder; only verified payloads are emitted.
module uart_frame_decoder
   import uart_frame_pkg::*;
#(
   parameter logic [7:0]  SYNC    = SYNC_BYTE,
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned TIMEOUT = 65536
) (
   input logic                 clk,
   input logic                 rst,
   uart_frame_decoder_if.slave bus
);

   localparam int unsigned LW = $clog2(MAX_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   state_t          state_q, state_d;
   logic [LW-1:0]   len_q, len_d, wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
   logic [7:0]      chk_q, chk_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            in_ack_q, in_ack_d, vld_q;
   logic            out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic            frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
   logic [1:0]      err_code_q, err_code_d;
   logic [7:0]      drop_q, drop_d;
   logic            cap_c, fire_c, tmo_hit_c, we_c;
   logic [AW-1:0]   rd_addr_c;
   logic [7:0]      rd_data;

   frame_buf #(.DEPTH(MAX_LEN)) u_buf (
      .clk   (clk),
      .we    (we_c),
      .waddr (AW'(wr_idx_q)),
      .wdata (bus.in_data),
      .raddr (rd_addr_c),
      .rdata (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HUNT;
         len_q       <= '0;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         chk_q       <= '0;
         tmo_q       <= '0;
         in_ack_q    <= 1'b0;
         vld_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= '0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         chk_q       <= chk_d;
         tmo_q       <= tmo_d;
         in_ack_q    <= in_ack_d;
         vld_q       <= bus.in_valid;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
         drop_q      <= drop_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      chk_d       = chk_q;
      tmo_d       = '0;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      drop_d      = drop_q;
      we_c        = 1'b0;
      rd_addr_c   = AW'(rd_idx_q);

      cap_c     = bus.in_valid && !in_ack_q && (state_q != SEND);
      fire_c    = out_valid_q && bus.out_ready;
      tmo_hit_c = (tmo_q == TW'(TIMEOUT - 1));
      in_ack_d  = cap_c ? 1'b1 : (bus.in_valid ? in_ack_q : 1'b0);

      if (state_q == LEN || state_q == PAYLOAD || state_q == CHK)
         tmo_d = cap_c ? '0 : TW'(tmo_q + 1'b1);

      // Bytes arriving during SEND are not consumed, only counted
      if (state_q == SEND && bus.in_valid && !vld_q && drop_q != 8'hFF)
         drop_d = 8'(drop_q + 1'b1);

      case (state_q)
         HUNT: begin
            if (cap_c && bus.in_data == SYNC) state_d = LEN;
         end
         LEN: begin
            if (cap_c) begin
               if (bus.in_data == 8'd0 || bus.in_data > 8'(MAX_LEN)) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_LEN;
                  state_d     = HUNT;
               end else begin
                  len_d    = LW'(bus.in_data);
                  chk_d    = bus.in_data;
                  wr_idx_d = '0;
                  state_d  = PAYLOAD;
               end
            end else if (tmo_hit_c) begin
               frame_err_d = 1'b1;
               err_code_d  = ERR_TMO;
               state_d     = HUNT;
            end
         end
         PAYLOAD: begin
            if (cap_c) begin
               we_c     = 1'b1;
               chk_d    = chk_q ^ bus.in_data;
               wr_idx_d = LW'(wr_idx_q + 1'b1);
               if (LW'(wr_idx_q + 1'b1) == len_q) state_d = CHK;
            end else if (tmo_hit_c) begin
               frame_err_d = 1'b1;
               err_code_d  = ERR_TMO;
               state_d     = HUNT;
            end
         end
         CHK: begin
            // rd_idx is 0 here, so the RAM already presents byte 0 on entry to SEND
            if (cap_c) begin
               if (bus.in_data == chk_q) begin
                  frame_ok_d  = 1'b1;
                  out_valid_d = 1'b1;
                  out_last_d  = (len_q == LW'(1));
                  rd_idx_d    = '0;
                  state_d     = SEND;
               end else begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_CHK;
                  state_d     = HUNT;
               end
            end else if (tmo_hit_c) begin
               frame_err_d = 1'b1;
               err_code_d  = ERR_TMO;
               state_d     = HUNT;
            end
         end
         SEND: begin
            if (fire_c) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  rd_idx_d    = '0;
                  rd_addr_c   = '0;
                  state_d     = HUNT;
               end else begin
                  rd_idx_d    = LW'(rd_idx_q + 1'b1);
                  rd_addr_c   = AW'(rd_idx_q + 1'b1);
                  out_last_d  = (LW'(rd_idx_q + 1'b1) == LW'(len_q - 1'b1));
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   assign bus.in_ack    = in_ack_q;
   assign bus.out_data  = rd_data;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.frame_ok  = frame_ok_q;
   assign bus.frame_err = frame_err_q;
   assign bus.err_code  = err_code_q;
   assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed self-checking bench for uart_frame_decoder (MAX_LEN=16, TIMEOUT=100).
module tb_uart_frame_decoder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_frame_decoder_if bus();

   uart_frame_decoder #(.SYNC(8'hA5), .MAX_LEN(16), .TIMEOUT(100)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   // observation log, sampled just after the falling edge
   int         ok_cnt, err_cnt, valid_cnt, nrx, ack_rises, stall_bad;
   int         ok_cyc, err_cyc, ack_cyc, first_vld_cyc;
   logic [1:0] err_seen;
   logic [7:0] rx_data [32];
   logic       rx_last [32];
   int         rx_cyc  [32];
   logic       ack_prev = 1'b0, stall_prev = 1'b0, last_prev = 1'b0;
   logic [7:0] data_prev = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      ok_cnt = 0; err_cnt = 0; valid_cnt = 0; nrx = 0; ack_rises = 0; stall_bad = 0;
      ok_cyc = -1; err_cyc = -1; first_vld_cyc = -2; err_seen = 2'd0;
   endtask

   always @(negedge clk) begin
      #1;
      if (bus.frame_ok) begin ok_cnt++; ok_cyc = cyc; end
      if (bus.frame_err) begin err_cnt++; err_cyc = cyc; err_seen = bus.err_code; end
      if (bus.in_ack && !ack_prev) begin ack_rises++; ack_cyc = cyc; end
      ack_prev = bus.in_ack;
      if (bus.out_valid) begin
         if (valid_cnt == 0) first_vld_cyc = cyc;
         valid_cnt++;
      end
      if (stall_prev && bus.out_valid && (bus.out_data !== data_prev || bus.out_last !== last_prev))
         stall_bad++;
      if (bus.out_valid && bus.out_ready && nrx < 32) begin
         rx_data[nrx] = bus.out_data;
         rx_last[nrx] = bus.out_last;
         rx_cyc[nrx]  = cyc;
         nrx++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      data_prev  = bus.out_data;
      last_prev  = bus.out_last;
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.in_ack && n < 20);
      if (!bus.in_ack) check("ack_timeout", 32'(bus.in_ack), 32'd1);
      bus.in_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] pat [4];
      pat[0] = 8'd1; pat[1] = 8'd0; pat[2] = 8'd0; pat[3] = 8'd1;
      rst = 1'b1;
      bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      clear_log();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst_in_ack",    32'(bus.in_ack),    32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_last",  32'(bus.out_last),  32'd0);
      check("rst_frame_ok",  32'(bus.frame_ok),  32'd0);
      check("rst_frame_err", 32'(bus.frame_err), 32'd0);
      check("rst_err_code",  32'(bus.err_code),  32'd0);
      check("rst_drop_cnt",  32'(bus.drop_cnt),  32'd0);

      // good frame A5 03 11 22 33 / 03
      clear_log();
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      send_byte(8'h03);
      repeat (8) @(negedge clk);
      check("good_ok_cnt",  32'(ok_cnt),  32'd1);
      check("good_err_cnt", 32'(err_cnt), 32'd0);
      check("good_nrx",     32'(nrx),     32'd3);
      check("good_d0", 32'(rx_data[0]), 32'h11);
      check("good_d1", 32'(rx_data[1]), 32'h22);
      check("good_d2", 32'(rx_data[2]), 32'h33);
      check("good_last", {29'd0, rx_last[0], rx_last[1], rx_last[2]}, 32'b001);
      check("good_consec01", 32'(rx_cyc[1] - rx_cyc[0]), 32'd1);
      check("good_consec12", 32'(rx_cyc[2] - rx_cyc[1]), 32'd1);
      check("good_ok_with_valid", 32'(first_vld_cyc), 32'(ok_cyc));

      // bad checksum A5 02 10 20 / FF (correct would be 32)
      clear_log();
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'hFF);
      repeat (4) @(negedge clk);
      check("badchk_err_cnt", 32'(err_cnt),   32'd1);
      check("badchk_code",    32'(err_seen),  32'd2);
      check("badchk_latency", 32'(err_cyc - ack_cyc), 32'd0);
      check("badchk_no_vld",  32'(valid_cnt), 32'd0);
      check("badchk_no_ok",   32'(ok_cnt),    32'd0);
      check("badchk_code_hold", 32'(bus.err_code), 32'd2);

      clear_log();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
      repeat (4) @(negedge clk);
      check("after_badchk_ok",   32'(ok_cnt),     32'd1);
      check("after_badchk_nrx",  32'(nrx),        32'd1);
      check("after_badchk_d0",   32'(rx_data[0]), 32'h7E);
      check("after_badchk_last", 32'(rx_last[0]), 32'd1);

      // bad lengths 0 and 17, then junk, then a good frame
      clear_log();
      send_byte(8'hA5); send_byte(8'h00);
      send_byte(8'hA5); send_byte(8'h11);
      send_byte(8'h33); send_byte(8'h44);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h55); send_byte(8'h54);
      repeat (4) @(negedge clk);
      check("badlen_err_cnt", 32'(err_cnt),    32'd2);
      check("badlen_code",    32'(err_seen),   32'd1);
      check("badlen_ok",      32'(ok_cnt),     32'd1);
      check("badlen_nrx",     32'(nrx),        32'd1);
      check("badlen_d0",      32'(rx_data[0]), 32'h55);

      // maximum length 16: payload 00..0F, checksum 10 ^ 00 ^ ... ^ 0F = 10
      clear_log();
      send_byte(8'hA5); send_byte(8'h10);
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      send_byte(8'h10);
      repeat (20) @(negedge clk);
      check("max_ok",  32'(ok_cnt), 32'd1);
      check("max_nrx", 32'(nrx),    32'd16);
      for (int i = 0; i < 16; i++) check($sformatf("max_d%0d", i), 32'(rx_data[i]), 32'(i));
      check("max_last15", 32'(rx_last[15]), 32'd1);
      check("max_last14", 32'(rx_last[14]), 32'd0);

      // timeout: A5 02 10 then silence
      clear_log();
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
      for (int i = 0; i < 300 && err_cnt == 0; i++) @(negedge clk);
      @(negedge clk);
      check("tmo_err_cnt", 32'(err_cnt),  32'd1);
      check("tmo_code",    32'(err_seen), 32'd3);
      check("tmo_latency", 32'(err_cyc - ack_cyc), 32'd100);
      check("tmo_no_ok",   32'(ok_cnt),   32'd0);

      // one byte held valid for 50 cycles: exactly one capture
      clear_log();
      bus.in_data = 8'h5A; bus.in_valid = 1'b1;
      repeat (50) @(negedge clk);
      check("hs_captures", 32'(ack_rises), 32'd1);
      check("hs_ack_held", 32'(bus.in_ack), 32'd1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("hs_ack_fall", 32'(bus.in_ack), 32'd0);

      // backpressure: A5 04 01 02 03 04 / 00, ready 1,0,0,1 repeating, one stray byte in SEND
      clear_log();
      bus.out_ready = 1'b0;
      send_byte(8'hA5); send_byte(8'h04);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h00);
      for (int i = 0; i < 20; i++) begin
         bus.out_ready = pat[i % 4][0];
         if (i == 1) begin bus.in_data = 8'hEE; bus.in_valid = 1'b1; end
         if (i == 3) bus.in_valid = 1'b0;
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("bp_ok",    32'(ok_cnt), 32'd1);
      check("bp_nrx",   32'(nrx),    32'd4);
      check("bp_d0", 32'(rx_data[0]), 32'h01);
      check("bp_d1", 32'(rx_data[1]), 32'h02);
      check("bp_d2", 32'(rx_data[2]), 32'h03);
      check("bp_d3", 32'(rx_data[3]), 32'h04);
      check("bp_last", {28'd0, rx_last[0], rx_last[1], rx_last[2], rx_last[3]}, 32'b0001);
      check("bp_stable", 32'(stall_bad), 32'd0);
      check("bp_drop_cnt", 32'(bus.drop_cnt), 32'd1);

      // reset in the middle of SEND: output vanishes, no status pulses
      bus.out_ready = 1'b0;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'h43);
      check("rs_in_send", 32'(bus.out_valid), 32'd1);
      clear_log();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rs_out_valid", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("rs_nrx",   32'(nrx),     32'd0);
      check("rs_no_ok", 32'(ok_cnt),  32'd0);
      check("rs_no_err", 32'(err_cnt), 32'd0);
      check("rs_drop_cnt", 32'(bus.drop_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
